glip_uart_rx_decode: RTL



---
 rtl/glip_uart_rx_decode.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/glip_uart_rx_decode.sv
//------------------------------------------------------------------------------
// glip_uart_rx_decode
//
// In-band control decoder that sits behind the UART receive CDC FIFO. It
// splits the raw host byte stream into user data and out-of-band control
// events. Control sequences begin with the escape byte ESC:
//   ESC ESC        -> literal data byte ESC
//   ESC 0x01 H L   -> credit grant {H[6:0], L} (H[7] set is a protocol error)
//   ESC 0x02       -> logic reset request
//   ESC other      -> protocol error, command byte dropped
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_data/in_valid/in_ready       byte input from the FWFT receive FIFO
//   out_data/out_valid/out_ready    decoded user data stream
//   credit_valid/credit_value       one-cycle credit grant event
//   logic_rst                       one-cycle logic reset request
//   rx_count                        delivered data bytes, wraps
//   error                           sticky protocol error, cleared by rst
//
// States:
//   S_DATA    | plain data; ESC opens a control sequence
//   S_ESC     | escape seen, next byte is the command
//   S_CRED_HI | waiting for the credit high byte
//   S_CRED_LO | waiting for the credit low byte
//------------------------------------------------------------------------------
module glip_uart_rx_decode #(
    parameter logic [7:0] ESC       = 8'hFE,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 credit_valid,
    output logic [14:0]          credit_value,
    output logic                 logic_rst,
    output logic [CNT_WIDTH-1:0] rx_count,
    output logic                 error
);

    typedef enum logic [1:0] {
        S_DATA    = 2'd0,
        S_ESC     = 2'd1,
        S_CRED_HI = 2'd2,
        S_CRED_LO = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_out_data;
    logic                   r_out_valid;
    logic                   r_credit_valid;
    logic [14:0]            r_credit_value;
    logic                   r_logic_rst;
    logic [CNT_WIDTH-1:0]   r_rx_count;
    logic                   r_error;
    logic [6:0]             r_hi;

    logic                   w_in_ready;
    logic                   w_take;
    logic                   w_out_hs;
    logic                   w_emit;
    logic                   w_credit;
    logic                   w_lrst;
    logic                   w_err;
    logic                   w_hi_load;

    // Control bytes are stalled by a blocked output too, which keeps the
    // handshake rule identical in every state.
    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_take     = in_valid & w_in_ready;
    assign w_out_hs   = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_credit    = 1'b0;
        w_lrst      = 1'b0;
        w_err       = 1'b0;
        w_hi_load   = 1'b0;
        if (w_take) begin
            case (r_state)
                S_DATA: begin
                    if (in_data == ESC) begin
                        w_state_nxt = S_ESC;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                S_ESC: begin
                    w_state_nxt = S_DATA;
                    if (in_data == ESC) begin
                        // in_data already equals ESC, so the data path can
                        // forward it unchanged.
                        w_emit = 1'b1;
                    end else if (in_data == 8'h01) begin
                        w_state_nxt = S_CRED_HI;
                    end else if (in_data == 8'h02) begin
                        w_lrst = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_CRED_HI: begin
                    w_hi_load = 1'b1;
                    if (in_data[7]) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_CRED_LO;
                    end
                end
                S_CRED_LO: begin
                    w_credit    = 1'b1;
                    w_state_nxt = S_DATA;
                end
                default: begin
                    w_state_nxt = S_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_DATA;
            r_out_data     <= 8'h00;
            r_out_valid    <= 1'b0;
            r_credit_valid <= 1'b0;
            r_credit_value <= 15'h0000;
            r_logic_rst    <= 1'b0;
            r_rx_count     <= '0;
            r_error        <= 1'b0;
            r_hi           <= 7'h00;
        end else begin
            r_state        <= w_state_nxt;
            r_credit_valid <= w_credit;
            r_logic_rst    <= w_lrst;
            r_error        <= r_error | w_err;

            // A new byte may load in the same cycle the old one hands off,
            // giving back-to-back throughput.
            if (w_emit) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            if (w_out_hs) begin
                r_rx_count <= r_rx_count + CNT_WIDTH'(1);
            end

            if (w_hi_load) begin
                r_hi <= in_data[6:0];
            end

            if (w_credit) begin
                r_credit_value <= {r_hi, in_data};
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign credit_valid = r_credit_valid;
    assign credit_value = r_credit_value;
    assign logic_rst    = r_logic_rst;
    assign rx_count     = r_rx_count;
    assign error        = r_error;

endmodule
